// File: rtl/core_v_mcu_pkg.sv
// Shared register-interface types for the MCU interconnect.
// Contents:
//   rule_t         - address-map rule: target port index plus a [start_addr, end_addr) window
//   reg_req_t      - register request (addr, write, wdata, wstrb, valid)
//   reg_rsp_t      - register response (rdata, error, ready)
//   ErrDataDefault - read data returned on any error
//   demux_state_e  - state encoding of the register demux
//   idx_width()    - bit width needed to hold a port index
package core_v_mcu_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  localparam logic [DataWidth-1:0] ErrDataDefault = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0]          idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_t;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RSP  = 2'd2
  } demux_state_e;

  // A single port still needs a 1-bit index signal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Combinational address decoder.
// Ports:
//   addr_i      - address to decode
//   addr_map_i  - NoRules rules, each mapping [start_addr, end_addr) to a port index
//   idx_o       - port index of the matching rule (0 when no rule matches)
//   dec_valid_o - a rule matched
//   dec_error_o - no rule matched
// Where rules overlap, the lowest-numbered rule wins. A rule whose index
// names a port that does not exist is skipped.
module addr_decode
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned NoIndices = 4,
  parameter int unsigned NoRules   = 4,
  parameter type addr_t = logic [AddrWidth-1:0],
  parameter type rule_t = core_v_mcu_pkg::rule_t
) (
  input  addr_t                              addr_i,
  input  rule_t                              addr_map_i [NoRules],
  output logic [idx_width(NoIndices)-1:0]    idx_o,
  output logic                               dec_valid_o,
  output logic                               dec_error_o
);

  localparam int unsigned IdxWidth = idx_width(NoIndices);

  // Scan from the highest rule down to rule 0. A later match overwrites an
  // earlier one, so the lowest-numbered matching rule is the result.
  always_comb begin
    idx_o       = '0;
    dec_valid_o = 1'b0;
    for (int i = int'(NoRules) - 1; i >= 0; i--) begin
      if ((addr_map_i[i].idx < 32'(NoIndices)) &&
          (addr_i >= addr_map_i[i].start_addr) &&
          (addr_i <  addr_map_i[i].end_addr)) begin
        idx_o       = IdxWidth'(addr_map_i[i].idx);
        dec_valid_o = 1'b1;
      end
    end
    dec_error_o = ~dec_valid_o;
  end

endmodule

// File: rtl/reg_demux_wdt.sv
// Register-interface demultiplexer with a watchdog on the downstream leg.
// Ports:
//   clk_i, rst_i     - clock; asynchronous active-high reset
//   addr_map_i       - NumRules address-map rules
//   in_req_i         - upstream request
//   in_rsp_o         - upstream response
//   out_req_o        - NumPorts downstream requests
//   out_rsp_i        - NumPorts downstream responses
//   dec_err_o        - one-cycle pulse on an unmapped access
//   timeout_o        - one-cycle pulse on a watchdog abort
//   err_cnt_o        - saturating count of decode errors and timeouts
//   last_err_addr_o  - address of the most recent error
//
// Handshake: the request is accepted in the cycle that valid is high and
// ready is high. The request stays stable from valid until ready, and ready
// is high only in the cycle that completes the transfer. The upstream side
// gets ready for exactly one cycle in RSP. On the downstream side the block
// holds valid on the selected port until that port raises ready or the
// watchdog expires.
// Only one transaction is outstanding at a time. Response data is
// registered, so a hit takes at least two cycles and a decode miss takes one.
module reg_demux_wdt
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned          NumPorts      = 4,
  parameter int unsigned          NumRules      = 4,
  parameter int unsigned          TimeoutCycles = 256,
  parameter logic [DataWidth-1:0] ErrData       = ErrDataDefault,
  parameter type req_t  = core_v_mcu_pkg::reg_req_t,
  parameter type rsp_t  = core_v_mcu_pkg::reg_rsp_t,
  parameter type rule_t = core_v_mcu_pkg::rule_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  rule_t                addr_map_i [NumRules],
  input  req_t                 in_req_i,
  output rsp_t                 in_rsp_o,
  output req_t                 out_req_o [NumPorts],
  input  rsp_t                 out_rsp_i [NumPorts],
  output logic                 dec_err_o,
  output logic                 timeout_o,
  output logic [15:0]          err_cnt_o,
  output logic [AddrWidth-1:0] last_err_addr_o
);

  localparam int unsigned IdxWidth = idx_width(NumPorts);
  localparam int unsigned WdtWidth = $clog2(TimeoutCycles + 1);
  localparam logic [WdtWidth-1:0] WdtLast = WdtWidth'(TimeoutCycles - 1);

  demux_state_e          state_q, state_d;
  logic [IdxWidth-1:0]   sel_q, sel_d;
  logic [WdtWidth-1:0]   wdt_q, wdt_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic                  dec_err_q, dec_err_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [AddrWidth-1:0]  last_err_addr_q, last_err_addr_d;
  logic                  err_event;

  logic [IdxWidth-1:0]   dec_idx;
  logic                  dec_valid;
  logic                  dec_error;

  addr_decode #(
    .NoIndices (NumPorts),
    .NoRules   (NumRules),
    .addr_t    (logic [AddrWidth-1:0]),
    .rule_t    (rule_t)
  ) u_addr_decode (
    .addr_i      (in_req_i.addr),
    .addr_map_i  (addr_map_i),
    .idx_o       (dec_idx),
    .dec_valid_o (dec_valid),
    .dec_error_o (dec_error)
  );

  // Next-state and registered-response logic.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    wdt_d           = wdt_q;
    rdata_d         = rdata_q;
    error_d         = error_q;
    dec_err_d       = 1'b0;
    timeout_d       = 1'b0;
    err_event       = 1'b0;
    err_cnt_d       = err_cnt_q;
    last_err_addr_d = last_err_addr_q;

    unique case (state_q)
      IDLE: begin
        if (in_req_i.valid) begin
          if (dec_valid) begin
            sel_d   = dec_idx;
            wdt_d   = '0;
            state_d = FWD;
          end else if (dec_error) begin
            rdata_d   = ErrData;
            error_d   = 1'b1;
            dec_err_d = 1'b1;
            err_event = 1'b1;
            state_d   = RSP;
          end
        end
      end
      FWD: begin
        wdt_d = wdt_q + WdtWidth'(1);
        // A downstream ready in the last watchdog cycle still completes
        // the transfer normally.
        if (out_rsp_i[sel_q].ready) begin
          rdata_d = out_rsp_i[sel_q].rdata;
          error_d = out_rsp_i[sel_q].error;
          state_d = RSP;
        end else if (wdt_q == WdtLast) begin
          rdata_d   = ErrData;
          error_d   = 1'b1;
          timeout_d = 1'b1;
          err_event = 1'b1;
          state_d   = RSP;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_event) begin
      err_cnt_d       = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      last_err_addr_d = in_req_i.addr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      sel_q           <= '0;
      wdt_q           <= '0;
      rdata_q         <= '0;
      error_q         <= 1'b0;
      dec_err_q       <= 1'b0;
      timeout_q       <= 1'b0;
      err_cnt_q       <= '0;
      last_err_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      wdt_q           <= wdt_d;
      rdata_q         <= rdata_d;
      error_q         <= error_d;
      dec_err_q       <= dec_err_d;
      timeout_q       <= timeout_d;
      err_cnt_q       <= err_cnt_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  // Downstream valid depends only on the state. Leaving FWD, including
  // through reset, drops it at once, and a late ready from a port is not
  // looked at outside FWD.
  always_comb begin
    in_rsp_o = '0;
    if (state_q == RSP) begin
      in_rsp_o.ready = 1'b1;
      in_rsp_o.rdata = rdata_q;
      in_rsp_o.error = error_q;
    end
    for (int unsigned p = 0; p < NumPorts; p++) begin
      out_req_o[p] = '0;
      if ((state_q == FWD) && (sel_q == IdxWidth'(p))) begin
        out_req_o[p]       = in_req_i;
        out_req_o[p].valid = 1'b1;
      end
    end
  end

  assign dec_err_o       = dec_err_q;
  assign timeout_o       = timeout_q;
  assign err_cnt_o       = err_cnt_q;
  assign last_err_addr_o = last_err_addr_q;

endmodule
